reaction_timer: RTL
===================

REACTION_TIMER -- requirements
Module: reaction_timer

Interface
REQ-001 Parameter LIGHTS_W, default 8, width of the light bar input.
REQ-002 Parameter DIGITS, default 4, number of BCD result digits.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 lights  input  LIGHTS_W  light bar from the start-light FSM; 0x01,0x03..0xFF during countdown, 0x00 at lights-out.
REQ-006 tick_ms  input  1  one-cycle strobe, once per millisecond, from a clock-tick divider.
REQ-007 button  input  1  raw asynchronous driver push-button, active-high.
REQ-008 result_bcd  output  4*DIGITS  latched reaction time in BCD, digit 0 in bits [3:0].
REQ-009 result_valid  output  1  one-cycle pulse when result_bcd is updated.
REQ-010 foul  output  1  level, high while the last run was a jump start.
REQ-011 timing  output  1  level, high while the reaction counter is running.

Function
REQ-012 button SHALL pass through a two-flop synchroniser; a press is a 0->1 edge of the synchronised signal, a one-cycle internal event.
REQ-013 States SHALL be IDLE, ARMED, TIMING, DONE, FOUL.
REQ-014 IDLE -> ARMED when lights == 0x01; counter cleared to 0 on this transition.
REQ-015 ARMED: press -> FOUL; registered previous lights == all-ones and current lights == 0x00 -> TIMING.
REQ-016 ARMED: press in the same cycle as lights-out -> FOUL (press wins).
REQ-017 TIMING: each tick_ms increments the DIGITS-digit BCD counter by 1; each digit wraps 9->0 with carry into the next digit.
REQ-018 TIMING: counter SHALL saturate at all-9s (9999 for DIGITS=4); further ticks hold it.
REQ-019 TIMING: press -> DONE; result_bcd loads the counter value, result_valid pulses high the next cycle only.
REQ-020 TIMING: press and tick_ms in the same cycle -> press wins, tick not counted.
REQ-021 Latency: result_bcd and result_valid SHALL change exactly one clock after the press event cycle.
REQ-022 FOUL: foul = 1, result_bcd forced to all-ones (0xFFFF, display blank), result_valid pulses once on entry.
REQ-023 DONE and FOUL SHALL hold outputs until lights == 0x01, then go to ARMED directly (new run), clearing foul.
REQ-024 Any non-monotonic lights value (e.g. 0x00 while ARMED without prior all-ones) SHALL return ARMED -> IDLE without output change.
REQ-025 Presses in IDLE, DONE and FOUL SHALL be ignored.
REQ-026 timing = 1 iff state == TIMING.

Reset
REQ-027 On rst low, asynchronously: state IDLE, counter 0, result_bcd 0, result_valid 0, foul 0, timing 0, synchroniser flops 0, previous-lights register 0.
REQ-028 Reset asserted mid-TIMING SHALL discard the run; no result_valid after release.
REQ-029 First press detectable no earlier than the third clock after reset release.

Structure
REQ-030 Shared package SHALL hold the state enum, ALL_ON constant (all-ones of LIGHTS_W), BLANK_BCD constant and the BCD digit width (4).
REQ-031 One sub-module bcd_counter SHALL implement the cascaded, clear-able, saturating BCD counter (inputs clr, inc; output digits).
REQ-032 Block SHALL be instantiated downstream of the start-light FSM, lights driven by its data_out.

Verification
REQ-033 Sequence 0x01..0xFF, 0x00; 237 tick_ms pulses; press -> result_bcd = 0x0237, result_valid one cycle, foul 0.
REQ-034 Press while lights = 0x1F -> FOUL, foul = 1, result_bcd = 0xFFFF; next 0x01 -> foul = 0, ARMED.
REQ-035 Press in same cycle lights go 0xFF->0x00 -> FOUL, not TIMING.
REQ-036 Lights-out, 10050 ticks, press -> result_bcd = 0x9999; counter stuck at 9999 after tick 9999.
REQ-037 Lights-out, 99 ticks, press coincident with 100th tick -> result_bcd = 0x0099 (carry 0099->0100 not taken).
REQ-038 Reset pulsed low mid-TIMING at count 0x0042 -> all outputs 0, state IDLE, no result_valid; subsequent full run measures correctly.

Source files
------------

// File: rtl/reaction_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reaction_timer_pkg
// Brief    : Shared state encoding and constants for the reaction timer.
// Revision : 1.0 - initial release
// ============================================================================
package reaction_timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_TIMING = 3'd2,
        ST_DONE   = 3'd3,
        ST_FOUL   = 3'd4
    } state_t;

    localparam int              BCD_W   = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    // Kept wide so any instance can slice them down to its own LIGHTS_W / DIGITS.
    localparam logic [63:0] ALL_ON    = '1;
    localparam logic [63:0] BLANK_BCD = '1;

endpackage
`default_nettype wire

// File: rtl/reaction_timer_bcd_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_counter
// Brief    : Cascaded multi-digit BCD counter with clear and saturation at 9s.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_counter
    import reaction_timer_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    inc,
    output logic [BCD_W*DIGITS-1:0] digits
);

    logic [DIGITS-1:0] w_nine;
    logic [DIGITS-1:0] w_carry;
    logic              w_sat;

    assign w_sat      = &w_nine;
    assign w_carry[0] = inc & ~w_sat;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            logic [BCD_W-1:0] r_digit;

            if (g > 0) begin : g_carry
                assign w_carry[g] = w_carry[g-1] & w_nine[g-1];
            end

            assign w_nine[g]                      = (r_digit == BCD_MAX);
            assign digits[g*BCD_W +: BCD_W]       = r_digit;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_digit <= '0;
                end else if (clr) begin
                    r_digit <= '0;
                end else if (w_carry[g]) begin
                    r_digit <= w_nine[g] ? '0 : r_digit + 4'd1;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/reaction_timer.sv
`default_nettype none
// ============================================================================
// Module   : reaction_timer
// Brief    : Measures driver reaction from lights-out to button press in BCD ms.
// Revision : 1.0 - initial release
// ============================================================================
module reaction_timer
    import reaction_timer_pkg::*;
#(
    parameter int LIGHTS_W = 8,
    parameter int DIGITS   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LIGHTS_W-1:0]     lights,
    input  logic                    tick_ms,
    input  logic                    button,
    output logic [BCD_W*DIGITS-1:0] result_bcd,
    output logic                    result_valid,
    output logic                    foul,
    output logic                    timing
);

    localparam logic [LIGHTS_W-1:0]     c_all_on      = ALL_ON[LIGHTS_W-1:0];
    localparam logic [LIGHTS_W-1:0]     c_light_first = {{(LIGHTS_W-1){1'b0}}, 1'b1};
    localparam logic [BCD_W*DIGITS-1:0] c_blank       = BLANK_BCD[BCD_W*DIGITS-1:0];

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_btn_meta;
    logic                    r_btn_sync;
    logic                    r_btn_sync_d;
    logic [LIGHTS_W-1:0]     r_prev_lights;
    logic [BCD_W*DIGITS-1:0] r_result;
    logic                    r_valid;
    logic                    r_foul;
    logic [BCD_W*DIGITS-1:0] w_count;
    logic                    w_press;
    logic                    w_step;
    logic                    w_clr;
    logic                    w_inc;
    logic                    w_done;
    logic                    w_jump;
    logic                    w_rearm;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_btn_meta    <= 1'b0;
            r_btn_sync    <= 1'b0;
            r_btn_sync_d  <= 1'b0;
            r_prev_lights <= '0;
        end else begin
            r_btn_meta    <= button;
            r_btn_sync    <= r_btn_meta;
            r_btn_sync_d  <= r_btn_sync;
            r_prev_lights <= lights;
        end
    end

    assign w_press = r_btn_sync & ~r_btn_sync_d;
    // A countdown may only hold its value or light one more lamp.
    assign w_step  = (lights == r_prev_lights) ||
                     (lights == {r_prev_lights[LIGHTS_W-2:0], 1'b1});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_inc       = 1'b0;
        w_done      = 1'b0;
        w_jump      = 1'b0;
        w_rearm     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (lights == c_light_first) begin
                    w_state_nxt = ST_ARMED;
                    w_clr       = 1'b1;
                end
            end
            ST_ARMED: begin
                if (w_press) begin
                    w_state_nxt = ST_FOUL;
                    w_jump      = 1'b1;
                end else if (r_prev_lights == c_all_on && lights == '0) begin
                    w_state_nxt = ST_TIMING;
                end else if (!w_step) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_TIMING: begin
                if (w_press) begin
                    w_state_nxt = ST_DONE;
                    w_done      = 1'b1;
                end else begin
                    w_inc = tick_ms;
                end
            end
            ST_DONE, ST_FOUL: begin
                if (lights == c_light_first) begin
                    w_state_nxt = ST_ARMED;
                    w_clr       = 1'b1;
                    w_rearm     = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    bcd_counter #(
        .DIGITS (DIGITS)
    ) u_counter (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_clr),
        .inc    (w_inc),
        .digits (w_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_result <= '0;
            r_valid  <= 1'b0;
            r_foul   <= 1'b0;
        end else begin
            r_valid <= w_done | w_jump;
            if (w_done) begin
                r_result <= w_count;
            end else if (w_jump) begin
                r_result <= c_blank;
            end
            if (w_jump) begin
                r_foul <= 1'b1;
            end else if (w_rearm) begin
                r_foul <= 1'b0;
            end
        end
    end

    assign result_bcd   = r_result;
    assign result_valid = r_valid;
    assign foul         = r_foul;
    assign timing       = (r_state == ST_TIMING);

endmodule
`default_nettype wire
